// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Multi-cycle ripple-borrow subtractor, d = a - b - bin.
//               Handles DIGIT bits per clock, LSB digit first, using a
//               start/busy/done handshake. Result is modulo 2^WIDTH and
//               bout flags unsigned underflow.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = $clog2(NDIG + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

  // A digit width that does not tile the operand cannot be processed cleanly.
  generate
    if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("serial_subtractor: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  logic [0:0]       state_q,  state_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic             borrow_q, borrow_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] d_q,      d_d;
  logic             bout_q,   bout_d;
  logic             done_q,   done_d;

  logic [DIGIT:0]   dig_diff;
  logic             last_digit;

  // Digit-slice subtraction; the extra top bit is the borrow into the next digit.
  always_comb begin
    dig_diff   = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]}
                 - {{DIGIT{1'b0}}, borrow_q};
    last_digit = (cnt_q == LAST_CNT);
  end

  // Next-state logic: IDLE accepts a request, BUSY runs until the last digit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)      state_d = S_BUSY;
      S_BUSY:  if (last_digit) state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  // Datapath next values: capture on accept, then one digit per BUSY cycle.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    d_d      = d_q;
    bout_d   = bout_q;
    done_d   = 1'b0;
    if (state_q == S_IDLE) begin
      if (start) begin
        a_d      = a;
        b_d      = b;
        borrow_d = bin;
        cnt_d    = '0;
      end
    end else begin
      for (int i = 0; i < NDIG; i++) begin
        if (cnt_q == CNT_W'(i)) d_d[i*DIGIT +: DIGIT] = dig_diff[DIGIT-1:0];
      end
      borrow_d = dig_diff[DIGIT];
      a_d      = a_q >> DIGIT;
      b_d      = b_q >> DIGIT;
      if (last_digit) begin
        // Counter clears on completion so the next op starts from slot 0.
        cnt_d  = '0;
        bout_d = dig_diff[DIGIT];
        done_d = 1'b1;
      end else begin
        cnt_d  = cnt_q + CNT_W'(1);
      end
    end
  end

  // State and datapath registers; reset abandons any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      d_q      <= '0;
      bout_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      d_q      <= d_d;
      bout_q   <= bout_d;
      done_q   <= done_d;
    end
  end

  // Output decode: busy follows the state, the rest come straight from flops.
  always_comb begin
    busy = (state_q == S_BUSY);
    done = done_q;
    d    = d_q;
    bout = bout_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Directed self-checking bench for serial_subtractor, covering
//               the bit-serial build plus 4-bit and full-width digit builds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;

  // Bit-serial instance (DIGIT = 1)
  logic       start1;
  logic [7:0] a1, b1;
  logic       bin1;
  logic       busy1, done1, bout1;
  logic [7:0] d1;

  // Shared stimulus for the DIGIT = 8 and DIGIT = 4 instances
  logic       sx;
  logic [7:0] ax, bx;
  logic       binx;
  logic       busy8, done8, bout8, busy4, done4, bout4;
  logic [7:0] d8, d4;

  int compared   = 0;
  int mismatched = 0;

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .d(d1), .bout(bout1)
  );

  serial_subtractor #(.WIDTH(8), .DIGIT(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(sx), .a(ax), .b(bx), .bin(binx),
    .busy(busy8), .done(done8), .d(d8), .bout(bout8)
  );

  serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(sx), .a(ax), .b(bx), .bin(binx),
    .busy(busy4), .done(done4), .d(d4), .bout(bout4)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance until done1 rises; n is the number of edges after the accept edge.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done1 && n < 20);
  endtask

  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic binv, input logic [7:0] exp_d, input logic exp_bout);
    int n;
    a1 = av; b1 = bv; bin1 = binv; start1 = 1'b1;
    tick();
    check({tag, ".busy_on_accept"}, busy1, 1);
    start1 = 1'b0;
    a1 = 8'hA5; b1 = 8'h5A; bin1 = ~binv;   // captured copies must be used
    wait_done(n);
    check({tag, ".latency"}, n, 8);
    check({tag, ".d"}, d1, exp_d);
    check({tag, ".bout"}, bout1, exp_bout);
    check({tag, ".busy_at_done"}, busy1, 0);
    tick();
    check({tag, ".done_drops"}, done1, 0);
    check({tag, ".d_holds"}, d1, exp_d);
  endtask

  logic [7:0] opa [5] = '{8'd10, 8'd3, 8'd128, 8'd0, 8'd0};
  logic [7:0] opb [5] = '{8'd3, 8'd10, 8'd127, 8'd1, 8'd0};
  logic [7:0] ope [4] = '{8'd7, 8'd249, 8'd1, 8'd255};
  logic       opo [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    int n;
    int pulses;
    logic [8:0] exp9;

    rst = 1'b1; start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
    sx = 1'b0; ax = '0; bx = '0; binx = 1'b0;
    tick(); tick();

    // Reset state
    check("rst.busy", busy1, 0);
    check("rst.done", done1, 0);
    check("rst.d", d1, 0);
    check("rst.bout", bout1, 0);
    check("rst.busy8", busy8, 0);
    check("rst.busy4", busy4, 0);
    rst = 1'b0;
    tick();

    // Basic subtraction and underflow / borrow-in corners
    run_op("t1_100m37", 8'd100, 8'd37, 1'b0, 8'd63, 1'b0);
    run_op("t2_5m10", 8'd5, 8'd10, 1'b0, 8'd251, 1'b1);
    run_op("t2_0m0b1", 8'd0, 8'd0, 1'b1, 8'd255, 1'b1);
    run_op("t2_255m255b1", 8'd255, 8'd255, 1'b1, 8'd255, 1'b1);

    // start while busy is ignored
    a1 = 8'd200; b1 = 8'd50; bin1 = 1'b0; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick(); tick();
    a1 = 8'd1; b1 = 8'd1; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n = 3;
    do begin tick(); n++; end while (!done1 && n < 20);
    check("t3.latency", n, 8);
    check("t3.d", d1, 150);
    check("t3.bout", bout1, 0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done1) pulses++;
    end
    check("t3.extra_done", pulses, 0);
    check("t3.idle", busy1, 0);

    // Reset mid-operation abandons the op
    a1 = 8'd100; b1 = 8'd37; bin1 = 1'b0; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    check("t4.busy", busy1, 0);
    check("t4.d", d1, 0);
    check("t4.bout", bout1, 0);
    check("t4.done", done1, 0);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done1) pulses++;
    end
    check("t4.no_done", pulses, 0);
    run_op("t4_fresh", 8'd9, 8'd4, 1'b0, 8'd5, 1'b0);

    // Back-to-back with start held high: one op per 9 cycles
    a1 = opa[0]; b1 = opb[0]; bin1 = 1'b0; start1 = 1'b1;
    tick();
    a1 = opa[1]; b1 = opb[1];
    for (int i = 0; i < 4; i++) begin
      wait_done(n);
      check($sformatf("t5.latency%0d", i), n, 8);
      check($sformatf("t5.d%0d", i), d1, ope[i]);
      check($sformatf("t5.bout%0d", i), bout1, opo[i]);
      if (i == 3) start1 = 1'b0;
      tick();
      if (i < 3) begin
        check($sformatf("t5.reaccept%0d", i), busy1, 1);
        a1 = opa[i+2]; b1 = opb[i+2];
      end else begin
        check("t5.stop", busy1, 0);
      end
    end

    // Wide digits: DIGIT=8 completes in 1 cycle, DIGIT=4 in 2 cycles
    for (int k = 0; k < 300; k++) begin
      ax = 8'($urandom); bx = 8'($urandom); binx = 1'($urandom);
      if (k == 0) begin ax = 8'd0; bx = 8'd255; binx = 1'b1; end
      exp9 = {1'b0, ax} - {1'b0, bx} - {8'd0, binx};
      sx = 1'b1;
      tick();
      sx = 1'b0;
      ax = ~ax; bx = ~bx;
      tick();
      check("t6.d8_done", done8, 1);
      check("t6.d8_res", {bout8, d8}, exp9);
      check("t6.d4_pending", done4, 0);
      tick();
      check("t6.d4_done", done4, 1);
      check("t6.d4_res", {bout4, d4}, exp9);
      check("t6.d8_hold", {done8, bout8, d8}, {1'b0, exp9});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
